// File: rtl/usb_rx_timer.sv
// Receive-side bit timing for the USB receiver: recovers bit timing from line edges,
// strobes mid-bit, counts data bits and bytes, and flags end-of-data and edge timeouts.
module usb_rx_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned SAMPLE_PT     = 4,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned MAX_BYTES     = 64,
  parameter int unsigned TIMEOUT_CLKS  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_en,
  input  logic       rx_rst,
  input  logic       d_edge,
  input  logic       stuff_bit,
  output logic       shift_strobe,
  output logic       byte_received,
  output logic [7:0] byte_count,
  output logic       eod,
  output logic       err
);

  localparam int unsigned WCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BCNT_W = $clog2(BITS_PER_BYTE + 1);
  localparam int unsigned ICNT_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [WCNT_W-1:0] WCNT_ZERO = '0;
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [WCNT_W-1:0] WCNT_SMP  = WCNT_W'(SAMPLE_PT);
  localparam logic [BCNT_W-1:0] BCNT_ZERO = '0;
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BITS_PER_BYTE - 1);
  localparam logic [ICNT_W-1:0] ICNT_ZERO = '0;
  localparam logic [ICNT_W-1:0] ICNT_ONE  = ICNT_W'(1);
  localparam logic [ICNT_W-1:0] ICNT_MAX  = ICNT_W'(TIMEOUT_CLKS);
  localparam logic [7:0]        BYTE_MAX  = 8'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [ICNT_W-1:0] r_icnt;
  logic [7:0]        r_byte_count;
  logic              r_byte_received;
  logic              r_eod;
  logic              r_err;

  state_t            w_state_nxt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic [BCNT_W-1:0] w_bit_cnt_nxt;
  logic [ICNT_W-1:0] w_icnt_nxt;
  logic [7:0]        w_byte_count_nxt;
  logic              w_byte_received_nxt;
  logic              w_eod_nxt;
  logic              w_err_nxt;
  logic              w_timeout;
  logic              w_last_byte;

  // Strobe is a pure decode of registered state, so a same-cycle edge cannot mask it.
  assign shift_strobe  = (r_state == S_RUN) && (r_wcnt == WCNT_SMP);
  assign byte_received = r_byte_received;
  assign byte_count    = r_byte_count;
  assign eod           = r_eod;
  assign err           = r_err;

  always_comb begin
    // NOTE: every value written here gets a default first, so no latch can be inferred.
    w_state_nxt         = r_state;
    w_wcnt_nxt          = r_wcnt;
    w_bit_cnt_nxt       = r_bit_cnt;
    w_icnt_nxt          = r_icnt;
    w_byte_count_nxt    = r_byte_count;
    w_byte_received_nxt = 1'b0;
    w_eod_nxt           = r_eod;
    w_err_nxt           = r_err;
    w_timeout           = 1'b0;
    w_last_byte         = 1'b0;

    if (rx_rst) begin
      w_state_nxt      = S_IDLE;
      w_wcnt_nxt       = WCNT_ZERO;
      w_bit_cnt_nxt    = BCNT_ZERO;
      w_icnt_nxt       = ICNT_ZERO;
      w_byte_count_nxt = 8'd0;
      w_eod_nxt        = 1'b0;
      w_err_nxt        = 1'b0;
    end else if (!rx_en) begin
      // Partial byte is dropped; byte total and sticky flags survive.
      w_state_nxt   = S_IDLE;
      w_wcnt_nxt    = WCNT_ZERO;
      w_bit_cnt_nxt = BCNT_ZERO;
      w_icnt_nxt    = ICNT_ZERO;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_eod)      w_state_nxt = S_DONE;
          else if (r_err) w_state_nxt = S_ERROR;
          else            w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          w_wcnt_nxt = WCNT_ZERO;
          if (d_edge) begin
            w_state_nxt = S_RUN;
            w_wcnt_nxt  = WCNT_ONE;
            w_icnt_nxt  = ICNT_ONE;
          end
        end
        S_RUN: begin
          // The edge cycle counts as width 0, hence reload to 1.
          if (d_edge)                  w_wcnt_nxt = WCNT_ONE;
          else if (r_wcnt == WCNT_MAX) w_wcnt_nxt = WCNT_ZERO;
          else                         w_wcnt_nxt = r_wcnt + WCNT_ONE;

          if (d_edge)                  w_icnt_nxt = ICNT_ONE;
          else if (r_icnt != ICNT_MAX) w_icnt_nxt = r_icnt + ICNT_ONE;

          w_timeout = !d_edge && (r_icnt == ICNT_MAX);

          if (shift_strobe && !stuff_bit) begin
            if (r_bit_cnt == BCNT_LAST) begin
              w_bit_cnt_nxt = BCNT_ZERO;
              if (r_byte_count != BYTE_MAX) begin
                w_byte_count_nxt    = r_byte_count + 8'd1;
                w_byte_received_nxt = 1'b1;
                w_last_byte         = (r_byte_count == BYTE_MAX - 8'd1);
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BCNT_ONE;
            end
          end

          // A finishing byte is always counted; reaching the limit outranks a timeout.
          if (w_last_byte) begin
            w_eod_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERROR;
          end
        end
        S_DONE, S_ERROR: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!n_rst) begin
      r_state         <= S_IDLE;
      r_wcnt          <= WCNT_ZERO;
      r_bit_cnt       <= BCNT_ZERO;
      r_icnt          <= ICNT_ZERO;
      r_byte_count    <= 8'd0;
      r_byte_received <= 1'b0;
      r_eod           <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wcnt          <= w_wcnt_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_icnt          <= w_icnt_nxt;
      r_byte_count    <= w_byte_count_nxt;
      r_byte_received <= w_byte_received_nxt;
      r_eod           <= w_eod_nxt;
      r_err           <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_usb_rx_timer.sv
// Scoreboard bench for usb_rx_timer: expected strobe and byte events are queued as
// stimulus is driven and matched by a monitor when the DUT produces them.
module tb_usb_rx_timer;

  localparam int BITS      = 8;
  localparam int MAX_BYTES = 64;

  logic       clk;
  logic       n_rst;
  logic       rx_en;
  logic       rx_rst;
  logic       d_edge;
  logic       stuff_bit;
  logic       shift_strobe;
  logic       byte_received;
  logic [7:0] byte_count;
  logic       eod;
  logic       err;

  usb_rx_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_en        (rx_en),
    .rx_rst       (rx_rst),
    .d_edge       (d_edge),
    .stuff_bit    (stuff_bit),
    .shift_strobe (shift_strobe),
    .byte_received(byte_received),
    .byte_count   (byte_count),
    .eod          (eod),
    .err          (err)
  );

  typedef struct {
    int cyc;
    int cnt;
    int eod;
  } byte_exp_t;

  int        strobe_q[$];
  byte_exp_t byte_q[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int tb_bits  = 0;
  int tb_bytes = 0;
  bit tb_done  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every strobe / byte pulse must match the head of its queue.
  always @(negedge clk) begin
    if (shift_strobe === 1'b1) begin
      int exp_cyc;
      exp_cyc = (strobe_q.size() > 0) ? strobe_q.pop_front() : -1;
      check("strobe_cycle", cyc, exp_cyc);
    end
    if (byte_received === 1'b1) begin
      byte_exp_t e;
      if (byte_q.size() > 0) e = byte_q.pop_front();
      else e = '{cyc: -1, cnt: -1, eod: -1};
      check("byte_cycle", cyc, e.cyc);
      check("byte_count_at_pulse", int'(byte_count), e.cnt);
      check("eod_at_pulse", int'(eod), e.eod);
    end
  end

  // One bit cell starting with an edge now; the strobe lands 4 clocks later.
  task automatic send_bit(input int period, input bit stuff);
    int s;
    s = cyc;
    if (!tb_done) begin
      strobe_q.push_back(s + 4);
      if (!stuff) begin
        tb_bits++;
        if (tb_bits == BITS) begin
          tb_bits = 0;
          if (tb_bytes < MAX_BYTES) begin
            tb_bytes++;
            byte_q.push_back('{cyc: s + 5, cnt: tb_bytes, eod: int'(tb_bytes == MAX_BYTES)});
            if (tb_bytes == MAX_BYTES) tb_done = 1'b1;
          end
        end
      end
    end
    for (int t = 0; t < period; t++) begin
      d_edge    = (t == 0);
      stuff_bit = (t == 4) && stuff;
      step();
    end
    d_edge    = 1'b0;
    stuff_bit = 1'b0;
  endtask

  task automatic arm();
    rx_en = 1'b1;
    step(2);
  endtask

  task automatic pulse_rx_rst();
    rx_rst = 1'b1;
    step();
    rx_rst   = 1'b0;
    tb_bits  = 0;
    tb_bytes = 0;
    tb_done  = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    step(12);
    check({tag, "_strobes_left"}, strobe_q.size(), 0);
    check({tag, "_bytes_left"}, byte_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    n_rst     = 1'b0;
    rx_en     = 1'b1;
    rx_rst    = 1'b0;
    d_edge    = 1'b0;
    stuff_bit = 1'b0;

    // 1. Reset with activity on the inputs, then idle with rx_en low.
    d_edge = 1'b1;
    step();
    d_edge = 1'b0;
    step();
    check("rst_strobe", int'(shift_strobe), 0);
    check("rst_byte_rx", int'(byte_received), 0);
    check("rst_byte_count", int'(byte_count), 0);
    check("rst_eod", int'(eod), 0);
    check("rst_err", int'(err), 0);
    n_rst = 1'b1;
    rx_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d_edge = (i % 2 == 0);
      step();
      check("idle_strobe", int'(shift_strobe), 0);
    end
    d_edge = 1'b0;
    check("idle_byte_count", int'(byte_count), 0);

    // 2. Basic byte: 8 regular bits.
    arm();
    for (int i = 0; i < 8; i++) send_bit(8, 1'b0);

    // 3. Late edge resync, plus one stuffed strobe among nine.
    send_bit(8, 1'b0);
    send_bit(10, 1'b0);
    send_bit(8, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(8, 1'b0);

    // 6. Mid-byte abort keeps byte_count and discards the partial byte.
    for (int i = 0; i < 5; i++) send_bit(8, 1'b0);
    rx_en = 1'b0;
    step();
    tb_bits = 0;
    check("abort_byte_count", int'(byte_count), 2);
    arm();
    for (int i = 0; i < 8; i++) send_bit(8, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(8, 1'b0);
    pulse_rx_rst();
    check("rx_rst_byte_count", int'(byte_count), 0);
    check("rx_rst_eod", int'(eod), 0);
    drain_check("abort");

    // 4. End of data after 64 bytes.
    for (int i = 0; i < MAX_BYTES * BITS; i++) send_bit(8, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(8, 1'b0);
    step(16);
    check("eod_held", int'(eod), 1);
    check("eod_byte_count", int'(byte_count), MAX_BYTES);
    check("eod_err", int'(err), 0);
    rx_en = 1'b0;
    step(2);
    check("eod_held_rx_en_low", int'(eod), 1);
    check("eod_count_rx_en_low", int'(byte_count), MAX_BYTES);
    pulse_rx_rst();
    check("eod_cleared", int'(eod), 0);
    check("eod_count_cleared", int'(byte_count), 0);
    drain_check("eod");

    // 5a. Timeout: no edges after the last one at cycle e.
    arm();
    send_bit(8, 1'b0);
    send_bit(8, 1'b0);
    e = cyc;
    send_bit(8, 1'b1);
    stuff_bit = 1'b1;
    for (int k = 12; k <= 60; k += 8) strobe_q.push_back(e + k);
    while (cyc < e + 64) step();
    check("timeout_err_before", int'(err), 0);
    step();
    check("timeout_err_set", int'(err), 1);
    step(20);
    check("timeout_err_held", int'(err), 1);
    stuff_bit = 1'b0;
    rx_en     = 1'b0;
    step(2);
    check("timeout_err_rx_en_low", int'(err), 1);
    pulse_rx_rst();
    check("timeout_err_cleared", int'(err), 0);
    drain_check("timeout");

    // 5b. An edge exactly at the timeout cycle prevents the error.
    arm();
    e = cyc;
    send_bit(8, 1'b1);
    stuff_bit = 1'b1;
    for (int k = 12; k <= 60; k += 8) strobe_q.push_back(e + k);
    while (cyc < e + 64) step();
    d_edge = 1'b1;
    check("edge_at_limit_err", int'(err), 0);
    step();
    d_edge    = 1'b0;
    stuff_bit = 1'b0;
    check("edge_at_limit_no_err", int'(err), 0);
    rx_en = 1'b0;
    step();
    check("edge_at_limit_still_no_err", int'(err), 0);
    tb_bits = 0;
    drain_check("edge_at_limit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
